// File: rtl/ir_transmitter_io.sv
// Bus-mapped IR transmitter: a periodic tick launches a carrier-modulated packet that
// encodes the F/B/L/R bits of CMD; STATUS is returned on the shared bus one cycle after a read.
module ir_transmitter_io #(
    parameter logic [7:0] BASE_ADDR      = 8'h90,
    parameter int         CLK_HZ         = 100_000_000,
    parameter int         CARRIER_HZ     = 36_000,
    parameter int         PACKET_HZ      = 10,
    parameter int         START_BURST    = 88,
    parameter int         GAP            = 40,
    parameter int         SELECT_BURST   = 22,
    parameter int         ASSERT_BURST   = 44,
    parameter int         DEASSERT_BURST = 22
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       IR_LED
);

    localparam int P_CYC = CLK_HZ / CARRIER_HZ;
    localparam int T_CYC = CLK_HZ / PACKET_HZ;
    localparam int CW    = $clog2(P_CYC + 1);
    localparam int TW    = $clog2(T_CYC + 1);

    localparam logic [CW-1:0] P_LAST      = CW'(P_CYC - 1);
    localparam logic [CW-1:0] P_HALF      = CW'(P_CYC / 2);
    localparam logic [TW-1:0] T_LAST      = TW'(T_CYC - 1);
    localparam logic [7:0]    STATUS_ADDR = BASE_ADDR + 8'd1;

    localparam logic [15:0] LEN_START  = 16'(START_BURST);
    localparam logic [15:0] LEN_GAP    = 16'(GAP);
    localparam logic [15:0] LEN_SELECT = 16'(SELECT_BURST);
    localparam logic [15:0] LEN_ASSERT = 16'(ASSERT_BURST);
    localparam logic [15:0] LEN_DEASRT = 16'(DEASSERT_BURST);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_GAP_START, S_SELECT, S_GAP_SELECT,
        S_R, S_GAP_R, S_L, S_GAP_L, S_B, S_GAP_B, S_F
    } state_t;

    state_t        state, state_next;
    logic [TW-1:0] tick_cnt;
    logic [CW-1:0] carrier_cnt;
    logic [15:0]   burst_cnt;
    logic [15:0]   seg_len;
    logic          cmd_en;
    logic [3:0]    cmd_dir;
    logic [3:0]    snap;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          tick, launch, carrier_wrap, seg_done, in_burst;
    logic          unused_bus_bits;

    assign tick         = (tick_cnt == T_LAST);
    assign launch       = tick && (state == S_IDLE) && cmd_en;
    assign carrier_wrap = (carrier_cnt == P_LAST);
    assign seg_done     = carrier_wrap && (burst_cnt == seg_len - 16'd1);

    function automatic logic [15:0] dir_len(input logic bit_set);
        return bit_set ? LEN_ASSERT : LEN_DEASRT;
    endfunction

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        seg_len    = 16'd1;
        in_burst   = 1'b0;
        case (state)
            S_IDLE:       if (launch) state_next = S_START;
            S_START:      begin seg_len = LEN_START;       in_burst = 1'b1; if (seg_done) state_next = S_GAP_START;  end
            S_GAP_START:  begin seg_len = LEN_GAP;                           if (seg_done) state_next = S_SELECT;     end
            S_SELECT:     begin seg_len = LEN_SELECT;      in_burst = 1'b1; if (seg_done) state_next = S_GAP_SELECT; end
            S_GAP_SELECT: begin seg_len = LEN_GAP;                           if (seg_done) state_next = S_R;          end
            S_R:          begin seg_len = dir_len(snap[3]); in_burst = 1'b1; if (seg_done) state_next = S_GAP_R;     end
            S_GAP_R:      begin seg_len = LEN_GAP;                           if (seg_done) state_next = S_L;          end
            S_L:          begin seg_len = dir_len(snap[2]); in_burst = 1'b1; if (seg_done) state_next = S_GAP_L;     end
            S_GAP_L:      begin seg_len = LEN_GAP;                           if (seg_done) state_next = S_B;          end
            S_B:          begin seg_len = dir_len(snap[1]); in_burst = 1'b1; if (seg_done) state_next = S_GAP_B;     end
            S_GAP_B:      begin seg_len = LEN_GAP;                           if (seg_done) state_next = S_F;          end
            S_F:          begin seg_len = dir_len(snap[0]); in_burst = 1'b1; if (seg_done) state_next = S_IDLE;      end
            default:      state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            carrier_cnt <= '0;
            burst_cnt   <= '0;
            snap        <= '0;
            IR_LED      <= 1'b0;
        end else begin
            state    <= state_next;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (launch) snap <= cmd_dir;
            // Both counters restart on every state entry, so segments abut with no idle cycles.
            if ((state == S_IDLE) || (state_next != state)) begin
                carrier_cnt <= '0;
                burst_cnt   <= '0;
            end else if (carrier_wrap) begin
                carrier_cnt <= '0;
                burst_cnt   <= burst_cnt + 16'd1;
            end else begin
                carrier_cnt <= carrier_cnt + CW'(1);
            end
            IR_LED <= in_burst && (carrier_cnt < P_HALF);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cmd_en   <= 1'b0;
            cmd_dir  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (BUS_WE && (BUS_ADDR == BASE_ADDR)) begin
                cmd_en  <= BUS_DATA[7];
                cmd_dir <= BUS_DATA[3:0];
            end
            rd_valid <= !BUS_WE && (BUS_ADDR == STATUS_ADDR);
            rd_data  <= {state != S_IDLE, 3'b000, snap};
        end
    end

    assign BUS_DATA        = rd_valid ? rd_data : 8'hzz;
    assign unused_bus_bits = &{1'b0, BUS_DATA[6:4]};

endmodule
